// File: rtl/captura_jogada_pkg.sv
// captura_pkg: shared types and helpers for the captura_jogada input stage.
//   estado_t           - control FSM states (2-bit encoding)
//   CODIGO_NENHUM      - code meaning "no selection"
//   onehot_para_codigo - lowest set bit index + 1 (0 when the vector is empty)
package captura_pkg;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    FILTRA   = 2'd1,
    REGISTRA = 2'd2,
    SOLTA    = 2'd3
  } estado_t;

  localparam int CODIGO_NENHUM = 0;

  // Scans from the top so the last write wins with the lowest set index.
  // For a one-hot vector this is exactly "button i -> i+1".
  function automatic logic [31:0] onehot_para_codigo(input logic [31:0] vetor);
    logic [31:0] codigo;
    codigo = 32'(CODIGO_NENHUM);
    for (int i = 31; i >= 0; i--) begin
      if (vetor[i]) codigo = 32'(i + 1);
    end
    return codigo;
  endfunction

endpackage

// File: rtl/captura_jogada_if.sv
// captura_jogada_if: player-selection bus between button source and capture stage.
//   botoes        - raw asynchronous buttons, active-high
//   habilita      - capture permitted
//   codigo        - encoded selection (0 = none, button i = i+1)
//   jogada_valida - one-cycle pulse, codigo valid
//   erro_multiplo - one-cycle pulse, more than one button in the stable pattern
//   ocupado       - capture FSM not idle
// Modports: master drives buttons/enable, slave is the capture stage.
interface captura_jogada_if #(
  parameter int N          = 4,
  parameter int NUM_BOTOES = 9
);
  logic [NUM_BOTOES-1:0] botoes;
  logic                  habilita;
  logic [N-1:0]          codigo;
  logic                  jogada_valida;
  logic                  erro_multiplo;
  logic                  ocupado;

  modport master (
    output botoes, habilita,
    input  codigo, jogada_valida, erro_multiplo, ocupado
  );

  modport slave (
    input  botoes, habilita,
    output codigo, jogada_valida, erro_multiplo, ocupado
  );
endinterface

// File: rtl/captura_jogada_contador_filtro.sv
// contador_filtro: stability counter shared by the press and release filters.
// Ports:
//   clock   - system clock
//   clear_n - synchronous active-low reset (count -> 0)
//   zera    - restart the count at 0
//   conta   - advance the count by one
//   fim     - count has reached DEBOUNCE_CYCLES-1
// The owner only asserts conta while fim is low, so the count never wraps.
module contador_filtro #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic clear_n,
  input  logic zera,
  input  logic conta,
  output logic fim
);
  localparam int W_RAW = $clog2(DEBOUNCE_CYCLES);
  localparam int W     = (W_RAW < 1) ? 1 : W_RAW;
  localparam logic [W-1:0] TERMINAL = W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim = (contagem == TERMINAL);
endmodule

// File: rtl/captura_jogada.sv
// captura_jogada: synchronises and debounces the player-selection buttons and
// encodes a single press into an N-bit code for the downstream selection
// register (codigo -> D, jogada_valida -> enable).
// Ports:
//   clock   - system clock, rising edge
//   clear_n - synchronous active-low reset
//   bus     - captura_jogada_if.slave (botoes, habilita in; codigo,
//             jogada_valida, erro_multiplo, ocupado out)
// Build option: CAPTURA_PRIORIDADE_EN - a multi-button pattern resolves to
// the lowest pressed index instead of raising erro_multiplo.
//
// State    | meaning
// ESPERA   | idle, waiting for an enabled non-zero pattern
// FILTRA   | pattern must stay identical for DEBOUNCE_CYCLES cycles
// REGISTRA | single cycle; the capture pulse is on the outputs
// SOLTA    | waiting for all buttons released for DEBOUNCE_CYCLES cycles
module captura_jogada
  import captura_pkg::*;
#(
  parameter int N               = 4,
  parameter int NUM_BOTOES      = 9,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              clear_n,
  captura_jogada_if.slave   bus
);

  logic [NUM_BOTOES-1:0] sinc_1;
  logic [NUM_BOTOES-1:0] sinc;
  logic [NUM_BOTOES-1:0] snapshot;
  estado_t               estado;
  estado_t               proximo;
  logic                  carrega_snap;
  logic                  zera;
  logic                  conta;
  logic                  captura;
  logic                  fim;
  logic [N-1:0]          codigo_q;
  logic [N-1:0]          codigo_snap;
  logic                  valida_q;
  logic                  erro_q;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      sinc_1 <= '0;
      sinc   <= '0;
    end else begin
      sinc_1 <= bus.botoes;
      sinc   <= sinc_1;
    end
  end

  contador_filtro #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_contador (
    .clock  (clock),
    .clear_n(clear_n),
    .zera   (zera),
    .conta  (conta),
    .fim    (fim)
  );

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      estado   <= ESPERA;
      snapshot <= '0;
    end else begin
      estado <= proximo;
      if (carrega_snap) snapshot <= sinc;
    end
  end

  always_comb begin
    proximo      = estado;
    carrega_snap = 1'b0;
    zera         = 1'b0;
    conta        = 1'b0;
    captura      = 1'b0;
    case (estado)
      ESPERA: begin
        if (bus.habilita && (sinc != '0)) begin
          carrega_snap = 1'b1;
          zera         = 1'b1;
          proximo      = FILTRA;
        end
      end
      FILTRA: begin
        if (!bus.habilita) begin
          proximo = ESPERA;
        end else if (sinc == '0) begin
          proximo = ESPERA;
        end else if (sinc != snapshot) begin
          carrega_snap = 1'b1;
          zera         = 1'b1;
        end else if (fim) begin
          // Outputs are loaded on this edge so the pulse and the new code
          // are both visible during the REGISTRA cycle.
          captura = 1'b1;
          proximo = REGISTRA;
        end else begin
          conta = 1'b1;
        end
      end
      REGISTRA: begin
        zera    = 1'b1;
        proximo = SOLTA;
      end
      SOLTA: begin
        if (sinc != '0) begin
          zera = 1'b1;
        end else if (fim) begin
          proximo = ESPERA;
        end else begin
          conta = 1'b1;
        end
      end
      default: proximo = ESPERA;
    endcase
  end

  assign codigo_snap = N'(onehot_para_codigo(32'(snapshot)));

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      codigo_q <= N'(CODIGO_NENHUM);
      valida_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      valida_q <= 1'b0;
      erro_q   <= 1'b0;
      if (captura) begin
`ifdef CAPTURA_PRIORIDADE_EN
        codigo_q <= codigo_snap;
        valida_q <= 1'b1;
`else
        if ($onehot(snapshot)) begin
          codigo_q <= codigo_snap;
          valida_q <= 1'b1;
        end else begin
          erro_q <= 1'b1;
        end
`endif
      end
    end
  end

  assign bus.codigo        = codigo_q;
  assign bus.jogada_valida = valida_q;
  assign bus.erro_multiplo = erro_q;
  assign bus.ocupado       = (estado != ESPERA);

endmodule

// File: tb/tb_captura_jogada.sv
// tb_captura_jogada: directed and randomized press scenarios for captura_jogada.
// The reference predicts each capture from the rules: pulse appears
// 2 + DEBOUNCE_CYCLES + 1 cycles after the last raw rise of an enabled press,
// a single button i gives code i+1, several buttons give an error pulse (or
// the lowest index when CAPTURA_PRIORIDADE_EN is defined). Every other cycle
// must show no pulse and the last captured code.
module tb_captura_jogada;
  localparam int N  = 4;
  localparam int NB = 9;
  localparam int DB = 4;
  localparam int LAT = 2 + DB + 1;

`ifdef CAPTURA_PRIORIDADE_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clock   = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  captura_jogada_if #(.N(N), .NUM_BOTOES(NB)) bus ();

  captura_jogada #(
    .N(N), .NUM_BOTOES(NB), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int n_checks = 0;
  int n_erros  = 0;

  logic [N-1:0] exp_code  = '0;
  int           pend_cyc  = -1;
  logic         pend_jv   = 1'b0;
  logic         pend_err  = 1'b0;
  logic [N-1:0] pend_code = '0;
  bit           chk_on    = 1'b0;

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, esp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      if (cyc == pend_cyc) begin
        confere("pulse_jv", 32'(bus.jogada_valida), 32'(pend_jv));
        confere("pulse_err", 32'(bus.erro_multiplo), 32'(pend_err));
        confere("pulse_busy", 32'(bus.ocupado), 32'd1);
        if (pend_jv) exp_code = pend_code;
        pend_cyc = -1;
      end else begin
        confere("no_jv", 32'(bus.jogada_valida), 32'd0);
        confere("no_err", 32'(bus.erro_multiplo), 32'd0);
      end
      confere("codigo", 32'(bus.codigo), 32'(exp_code));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Expected outcome of a stable pattern captured at cycle c_pulse.
  task automatic prever(input logic [NB-1:0] pat, input int c_pulse);
    int low;
    low = 0;
    for (int i = NB - 1; i >= 0; i--) if (pat[i]) low = i;
    pend_cyc = c_pulse;
    if ($countones(pat) == 1 || PRIO) begin
      pend_jv   = 1'b1;
      pend_err  = 1'b0;
      pend_code = N'(low + 1);
    end else begin
      pend_jv  = 1'b0;
      pend_err = 1'b1;
    end
  endtask

  task automatic pressiona(input logic [NB-1:0] pat, input int nbounce,
                           input int max_esp, input int hold);
    for (int b = 0; b < nbounce; b++) begin
      bus.botoes = pat;
      tick($urandom_range(1, max_esp));
      bus.botoes = '0;
      tick($urandom_range(1, max_esp));
    end
    bus.botoes = pat;
    if (bus.habilita) prever(pat, cyc + LAT);
    tick(hold);
    bus.botoes = '0;
    tick(12);
    confere("idle_busy", 32'(bus.ocupado), 32'd0);
  endtask

  task automatic aplica_reset(input int n);
    clear_n = 1'b0;
    tick(1);
    exp_code = '0;
    pend_cyc = -1;
    if (n > 1) tick(n - 1);
    clear_n = 1'b1;
  endtask

  initial begin
    int h;
    logic [NB-1:0] pat;

    bus.botoes   = '1;
    bus.habilita = 1'b0;
    clear_n      = 1'b0;
    tick(2);
    exp_code = '0;
    chk_on   = 1'b1;
    confere("rst_codigo", 32'(bus.codigo), 32'd0);
    confere("rst_jv", 32'(bus.jogada_valida), 32'd0);
    confere("rst_err", 32'(bus.erro_multiplo), 32'd0);
    confere("rst_busy", 32'(bus.ocupado), 32'd0);
    bus.botoes = '0;
    clear_n    = 1'b1;
    tick(5);
    confere("post_rst_busy", 32'(bus.ocupado), 32'd0);

    // clean press, then 20 more held cycles
    bus.habilita = 1'b1;
    tick(1);
    pressiona(9'b000000100, 0, 1, LAT + 20);

    // bounce at 1-cycle spacing
    pressiona(9'b000000001, 2, 1, 15);

    // two buttons together
    pressiona(9'b100000001, 0, 1, 10);

    // gated: habilita low
    bus.habilita = 1'b0;
    tick(1);
    pressiona(9'h100, 0, 1, 15);

    // habilita falls while filtering
    bus.habilita = 1'b1;
    tick(1);
    bus.botoes = 9'h100;
    tick(4);
    bus.habilita = 1'b0;
    tick(10);
    confere("hab_drop_busy", 32'(bus.ocupado), 32'd0);
    bus.botoes = '0;
    tick(6);
    bus.habilita = 1'b1;
    tick(1);
    pressiona(9'h100, 0, 1, 12);

    // reset while releasing with the button still held
    bus.botoes = 9'h010;
    prever(9'h010, cyc + LAT);
    tick(LAT + 3);
    confere("solta_busy", 32'(bus.ocupado), 32'd1);
    bus.habilita = 1'b0;
    aplica_reset(1);
    confere("midrst_busy", 32'(bus.ocupado), 32'd0);
    tick(15);
    confere("held_nohab_busy", 32'(bus.ocupado), 32'd0);
    bus.habilita = 1'b1;
    h = cyc;
    prever(9'h010, h + 1 + DB);
    tick(12);
    bus.botoes = '0;
    tick(12);
    confere("recapture_idle", 32'(bus.ocupado), 32'd0);

    // randomized presses
    repeat (24) begin
      bus.habilita = ($urandom_range(0, 4) != 0);
      tick(2);
      if ($urandom_range(0, 2) != 0) pat = NB'(1) << $urandom_range(0, NB - 1);
      else                           pat = NB'($urandom_range(1, (1 << NB) - 1));
      pressiona(pat, $urandom_range(0, 3), 3, $urandom_range(10, 20));
    end

    tick(2);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
    $finish;
  end
endmodule
